// File: rtl/rs_alu_issue_pkg.sv
// rs_alu_issue_pkg: shared sizing constants and the wakeup-slot record for the ALU issue block
package rs_alu_issue_pkg;
  localparam int ENT_NUM = 16;
  localparam int ENT_SEL = 4;
  localparam int RRF_SEL = 6;
  localparam int SPECTAG_LEN = 5;
  localparam int DLY_LEN = 2;
  localparam int MAX_DLY = 3;
  typedef struct packed {
    logic valid;
    logic [RRF_SEL-1:0] rrftag;
    logic [SPECTAG_LEN-1:0] spectag;
    logic [DLY_LEN-1:0] countdown;
  } wake_slot_t;
endpackage

// File: rtl/rs_alu_age_sel.sv
// rs_alu_age_sel: eligible-vector to index picker; RS_ALU_ISSUE_AGE_EN selects oldest (rrftag-rrfptr), else lowest index
module rs_alu_age_sel
  import rs_alu_issue_pkg::*;
#(
  parameter int ENT_NUM = rs_alu_issue_pkg::ENT_NUM,
  parameter int ENT_SEL = rs_alu_issue_pkg::ENT_SEL,
  parameter int RRF_SEL = rs_alu_issue_pkg::RRF_SEL
) (
  input  logic [ENT_NUM-1:0]         elig,
  input  logic [ENT_NUM*RRF_SEL-1:0] age_vec,
  input  logic [RRF_SEL-1:0]         rrfptr,
  output logic                       sel,
  output logic [ENT_SEL-1:0]         idx
);
`ifdef RS_ALU_ISSUE_AGE_EN
  logic [RRF_SEL-1:0] age, best;
  always_comb begin
    sel = 1'b0;
    idx = '0;
    best = '0;
    age = '0;
    for (int i = 0; i < ENT_NUM; i++) begin
      age = age_vec[i*RRF_SEL +: RRF_SEL] - rrfptr;
      if (elig[i] && (!sel || age < best)) begin
        sel = 1'b1;
        idx = i[ENT_SEL-1:0];
        best = age;
      end
    end
  end
`else
  logic unused_age;
  assign unused_age = ^{age_vec, rrfptr};
  always_comb begin
    sel = 1'b0;
    idx = '0;
    for (int i = ENT_NUM - 1; i >= 0; i--) begin
      if (elig[i]) begin
        sel = 1'b1;
        idx = i[ENT_SEL-1:0];
      end
    end
  end
`endif
endmodule

// File: rtl/rs_alu_issue.sv
// rs_alu_issue: ALU reservation-station select, issue register and delayed wakeup; RS_ALU_ISSUE_AGE_EN enables oldest-first select
module rs_alu_issue
  import rs_alu_issue_pkg::*;
#(
  parameter int ENT_NUM = rs_alu_issue_pkg::ENT_NUM,
  parameter int ENT_SEL = rs_alu_issue_pkg::ENT_SEL,
  parameter int RRF_SEL = rs_alu_issue_pkg::RRF_SEL,
  parameter int SPECTAG_LEN = rs_alu_issue_pkg::SPECTAG_LEN,
  parameter int DLY_LEN = rs_alu_issue_pkg::DLY_LEN
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ENT_NUM-1:0]             ready_vec,
  input  logic [ENT_NUM*RRF_SEL-1:0]     age_vec,
  input  logic [ENT_NUM*DLY_LEN-1:0]     dly_vec,
  input  logic [ENT_NUM-1:0]             dst_vec,
  input  logic [ENT_NUM*SPECTAG_LEN-1:0] spec_vec,
  input  logic [RRF_SEL-1:0]             rrfptr,
  input  logic                           prmiss,
  input  logic [SPECTAG_LEN-1:0]         specfixtag,
  input  logic                           exe_stall,
  output logic                           clear_busy,
  output logic [ENT_SEL-1:0]             issue_addr,
  output logic                           iss_valid,
  output logic [ENT_SEL-1:0]             iss_addr,
  output logic [SPECTAG_LEN-1:0]         iss_spectag,
  output logic                           wake_valid,
  output logic [RRF_SEL-1:0]             wake_rrftag
);
  wake_slot_t [MAX_DLY:0] slot, slot_n;
  logic [MAX_DLY:0] resv, resv_sh;
  logic [ENT_NUM-1:0] elig;
  logic ld, sel;
  logic [ENT_SEL-1:0] idx;
  logic [DLY_LEN-1:0] d;
  logic [RRF_SEL-1:0] tag;
  logic [SPECTAG_LEN-1:0] spec;
  always_comb begin
    for (int k = 0; k <= MAX_DLY; k++) resv[k] = slot[k].valid;
    resv_sh = exe_stall ? resv : resv >> 1;
    ld = !exe_stall || !iss_valid;
    for (int i = 0; i < ENT_NUM; i++)
      elig[i] = !rst && ld && ready_vec[i] && !resv_sh[dly_vec[i*DLY_LEN +: DLY_LEN]] &&
                !(prmiss && |(spec_vec[i*SPECTAG_LEN +: SPECTAG_LEN] & specfixtag));
    wake_valid = !exe_stall && slot[0].valid && slot[0].countdown == '0 &&
                 !(prmiss && |(slot[0].spectag & specfixtag));
    wake_rrftag = wake_valid ? slot[0].rrftag : '0;
  end
  rs_alu_age_sel #(.ENT_NUM(ENT_NUM), .ENT_SEL(ENT_SEL), .RRF_SEL(RRF_SEL)) u_sel (
    .elig(elig),
    .age_vec(age_vec),
    .rrfptr(rrfptr),
    .sel(sel),
    .idx(idx)
  );
  always_comb begin
    clear_busy = sel;
    issue_addr = idx;
    d = dly_vec[idx*DLY_LEN +: DLY_LEN];
    tag = age_vec[idx*RRF_SEL +: RRF_SEL];
    spec = spec_vec[idx*SPECTAG_LEN +: SPECTAG_LEN];
    slot_n = exe_stall ? slot : slot >> $bits(wake_slot_t);
    for (int k = 0; k <= MAX_DLY; k++) begin
      if (!exe_stall) slot_n[k].countdown = slot_n[k].countdown - 1'b1;
      if (prmiss && |(slot_n[k].spectag & specfixtag)) slot_n[k].valid = 1'b0;
    end
    if (sel && dst_vec[idx]) slot_n[d] = '{valid: 1'b1, rrftag: tag, spectag: spec, countdown: d};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_valid <= 1'b0;
      iss_addr <= '0;
      iss_spectag <= '0;
      slot <= '0;
    end else begin
      iss_valid <= ld ? sel : iss_valid && !(prmiss && |(iss_spectag & specfixtag));
      if (sel) begin
        iss_addr <= idx;
        iss_spectag <= spec;
      end
      slot <= slot_n;
    end
  end
endmodule

// File: tb/tb_rs_alu_issue.sv
// tb_rs_alu_issue: vector table plus corner sequences with a wakeup scoreboard for rs_alu_issue
module tb_rs_alu_issue;
  localparam int N = 16, ES = 4, RS = 6, SL = 5, DL = 2, NV = 10;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] ready_vec, dst_vec;
  logic [N*RS-1:0] age_vec;
  logic [N*DL-1:0] dly_vec;
  logic [N*SL-1:0] spec_vec;
  logic [RS-1:0] rrfptr;
  logic prmiss, exe_stall;
  logic [SL-1:0] specfixtag;
  logic clear_busy, iss_valid, wake_valid;
  logic [ES-1:0] issue_addr, iss_addr;
  logic [SL-1:0] iss_spectag;
  logic [RS-1:0] wake_rrftag;
  typedef struct {
    int cyc;
    logic [RS-1:0] tag;
  } wake_t;
  typedef struct {
    logic [N-1:0] ready;
    int i0;
    logic [RS-1:0] t0;
    int i1;
    logic [RS-1:0] t1;
    logic [RS-1:0] ptr;
    logic [DL-1:0] dly;
    logic dst;
    logic [N-1:0] kmask;
    logic pm;
    logic esel;
    int eage;
    int elow;
  } vec_t;
  wake_t exp_q[$];
  vec_t tv[NV];
  int checks = 0, errors = 0, cyc = 0;
  always #5 clk = ~clk;
  rs_alu_issue dut (
    .clk(clk), .rst(rst), .ready_vec(ready_vec), .age_vec(age_vec), .dly_vec(dly_vec),
    .dst_vec(dst_vec), .spec_vec(spec_vec), .rrfptr(rrfptr), .prmiss(prmiss),
    .specfixtag(specfixtag), .exe_stall(exe_stall), .clear_busy(clear_busy),
    .issue_addr(issue_addr), .iss_valid(iss_valid), .iss_addr(iss_addr),
    .iss_spectag(iss_spectag), .wake_valid(wake_valid), .wake_rrftag(wake_rrftag)
  );
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (!rst) begin
      if (wake_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL wake_spurious cyc=%0d tag=%0h expected no wake", cyc, wake_rrftag);
        end else begin
          wake_t e;
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.tag != wake_rrftag) begin
            errors++;
            $display("FAIL wake got cyc=%0d tag=%0h expected cyc=%0d tag=%0h", cyc, wake_rrftag, e.cyc, e.tag);
          end
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        wake_t e;
        checks++;
        errors++;
        e = exp_q.pop_front();
        $display("FAIL wake_missing cyc=%0d got none expected tag=%0h at cyc=%0d", cyc, e.tag, e.cyc);
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    ready_vec = '0;
    dst_vec = '1;
    prmiss = 1'b0;
    specfixtag = '0;
    exe_stall = 1'b0;
    rrfptr = '0;
    dly_vec = '0;
    for (int i = 0; i < N; i++) begin
      age_vec[i*RS +: RS] = 6'(i * 3);
      spec_vec[i*SL +: SL] = 5'b00001;
    end
  endtask
  task automatic set_ent(input int i, input logic [RS-1:0] t, input logic [DL-1:0] d, input logic [SL-1:0] s);
    age_vec[i*RS +: RS] = t;
    dly_vec[i*DL +: DL] = d;
    spec_vec[i*SL +: SL] = s;
  endtask
  task automatic push(input int c, input logic [RS-1:0] t);
    exp_q.push_back('{cyc: c, tag: t});
  endtask
  task automatic chk_zero(input string p);
    chk({p, "_clear_busy"}, clear_busy, 0);
    chk({p, "_issue_addr"}, issue_addr, 0);
    chk({p, "_iss_valid"}, iss_valid, 0);
    chk({p, "_iss_addr"}, iss_addr, 0);
    chk({p, "_iss_spectag"}, iss_spectag, 0);
    chk({p, "_wake_valid"}, wake_valid, 0);
    chk({p, "_wake_rrftag"}, wake_rrftag, 0);
  endtask
  function automatic vec_t mkv(input logic [N-1:0] r, input int i0, input logic [RS-1:0] t0,
                               input int i1, input logic [RS-1:0] t1, input logic [RS-1:0] p,
                               input logic [DL-1:0] d, input logic ds, input logic [N-1:0] km,
                               input logic pm, input logic es, input int ea, input int el);
    vec_t x;
    x.ready = r; x.i0 = i0; x.t0 = t0; x.i1 = i1; x.t1 = t1; x.ptr = p; x.dly = d;
    x.dst = ds; x.kmask = km; x.pm = pm; x.esel = es; x.eage = ea; x.elow = el;
    return x;
  endfunction
  initial begin
    #100000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    int ex;
    tv[0] = mkv(16'h0000, -1, 0, -1, 0, 6'h00, 0, 1, 16'h0000, 0, 0, 0, 0);
    tv[1] = mkv(16'h0208, 3, 6'h05, 9, 6'h02, 6'h00, 0, 1, 16'h0000, 0, 1, 9, 3);
    tv[2] = mkv(16'h0084, 7, 6'h3E, 2, 6'h01, 6'h3C, 1, 1, 16'h0000, 0, 1, 7, 2);
    tv[3] = mkv(16'h0810, 4, 6'h10, 11, 6'h10, 6'h00, 2, 1, 16'h0000, 0, 1, 4, 4);
    tv[4] = mkv(16'h8000, -1, 0, -1, 0, 6'h00, 3, 1, 16'h0000, 0, 1, 15, 15);
    tv[5] = mkv(16'hFFFF, -1, 0, -1, 0, 6'h20, 0, 1, 16'h0000, 0, 1, 11, 0);
    tv[6] = mkv(16'h0022, -1, 0, -1, 0, 6'h00, 1, 1, 16'h0002, 1, 1, 5, 5);
    tv[7] = mkv(16'h0022, -1, 0, -1, 0, 6'h00, 0, 1, 16'h0022, 1, 0, 0, 0);
    tv[8] = mkv(16'h0040, -1, 0, -1, 0, 6'h00, 2, 0, 16'h0000, 0, 1, 6, 6);
    tv[9] = mkv(16'h0003, 0, 6'h3B, 1, 6'h3C, 6'h3C, 0, 1, 16'h0000, 0, 1, 1, 0);
    rst = 1'b1;
    idle();
    ready_vec = '1;
    tick();
    chk_zero("reset");
    tick();
    rst = 1'b0;
    ready_vec = '0;
    tick();
    for (int v = 0; v < NV; v++) begin
      idle();
      ready_vec = tv[v].ready;
      if (tv[v].i0 >= 0) age_vec[tv[v].i0*RS +: RS] = tv[v].t0;
      if (tv[v].i1 >= 0) age_vec[tv[v].i1*RS +: RS] = tv[v].t1;
      rrfptr = tv[v].ptr;
      for (int i = 0; i < N; i++) begin
        dly_vec[i*DL +: DL] = tv[v].dly;
        dst_vec[i] = tv[v].dst;
        if (tv[v].kmask[i]) spec_vec[i*SL +: SL] = 5'b00100;
      end
      prmiss = tv[v].pm;
      specfixtag = tv[v].pm ? 5'b00100 : 5'b00000;
`ifdef RS_ALU_ISSUE_AGE_EN
      ex = tv[v].eage;
`else
      ex = tv[v].elow;
`endif
      #1;
      chk($sformatf("v%0d_clear_busy", v), clear_busy, tv[v].esel);
      if (tv[v].esel) chk($sformatf("v%0d_issue_addr", v), issue_addr, ex);
      if (tv[v].esel && tv[v].dst) push(cyc + 1 + int'(tv[v].dly), age_vec[ex*RS +: RS]);
      tick();
      idle();
      chk($sformatf("v%0d_iss_valid", v), iss_valid, tv[v].esel);
      if (tv[v].esel) chk($sformatf("v%0d_iss_addr", v), iss_addr, ex);
      repeat (5) tick();
    end
    idle();
    set_ent(2, 6'h11, 2, 5'b00001);
    set_ent(5, 6'h22, 1, 5'b00001);
    ready_vec = 16'h0004;
    #1;
    chk("col_a_sel", clear_busy, 1);
    chk("col_a_addr", issue_addr, 2);
    push(cyc + 3, 6'h11);
    tick();
    ready_vec = 16'h0020;
    #1;
    chk("col_b_blocked", clear_busy, 0);
    tick();
    #1;
    chk("col_b_sel", clear_busy, 1);
    chk("col_b_addr", issue_addr, 5);
    push(cyc + 2, 6'h22);
    tick();
    ready_vec = '0;
    repeat (5) tick();
    idle();
    set_ent(3, 6'h2A, 0, 5'b00001);
    set_ent(8, 6'h2B, 0, 5'b00001);
    ready_vec = 16'h0008;
    #1;
    chk("st_sel", clear_busy, 1);
    chk("st_addr", issue_addr, 3);
    push(cyc + 4, 6'h2A);
    tick();
    ready_vec = 16'h0100;
    exe_stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk($sformatf("st%0d_clear_busy", s), clear_busy, 0);
      chk($sformatf("st%0d_iss_valid", s), iss_valid, 1);
      chk($sformatf("st%0d_iss_addr", s), iss_addr, 3);
      tick();
    end
    exe_stall = 1'b0;
    ready_vec = '0;
    #1;
    chk("st_hold_valid", iss_valid, 1);
    repeat (5) tick();
    idle();
    set_ent(4, 6'h33, 2, 5'b00100);
    ready_vec = 16'h0010;
    #1;
    chk("k_sel", clear_busy, 1);
    tick();
    ready_vec = '0;
    prmiss = 1'b1;
    specfixtag = 5'b00100;
    #1;
    chk("k_spectag", iss_spectag, 5'b00100);
    chk("k_valid", iss_valid, 1);
    tick();
    prmiss = 1'b0;
    specfixtag = '0;
    #1;
    chk("k_dropped", iss_valid, 0);
    repeat (5) tick();
    idle();
    set_ent(0, 6'h01, 3, 5'b00001);
    set_ent(1, 6'h02, 1, 5'b00001);
    ready_vec = 16'h0001;
    #1;
    chk("r_sel0", clear_busy, 1);
    tick();
    ready_vec = 16'h0002;
    #1;
    chk("r_sel1", clear_busy, 1);
    chk("r_addr1", issue_addr, 1);
    tick();
    ready_vec = '1;
    rst = 1'b1;
    #1;
    chk("r_busy_in_reset", clear_busy, 0);
    tick();
    rst = 1'b0;
    ready_vec = '0;
    #1;
    chk_zero("r_after");
    repeat (6) tick();
    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
